// File: rtl/lfo_rate_pkg.sv
// lfo_rate_pkg: shared state encoding, channel index width and glide arithmetic for lfo_rate_control.
package lfo_rate_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_EMIT} state_t;

    localparam int MAX_CHANNELS = 8;
    localparam int CH_W         = $clog2(MAX_CHANNELS);

    // One slew step towards target; never stalls short of it thanks to the +/-1 floor.
    function automatic logic signed [31:0] glide_step(
        input logic signed [31:0] target,
        input logic signed [31:0] cur,
        input int                 shift
    );
        logic signed [31:0] diff;
        logic signed [31:0] step;
        diff = target - cur;
        step = diff >>> shift;
        return (step == 0 && diff != 0) ? ((diff < 0) ? -32'sd1 : 32'sd1) : step;
    endfunction

endpackage

// File: rtl/rom_tremolo.sv
// rom_tremolo: registered rate->increment table, one cycle read latency.
// Contents are the built-in linear curve word = addr * 2**DWIDTH / 2**AWIDTH; external tables are rejected.
module rom_tremolo #(
    parameter int    DWIDTH    = 17,
    parameter int    AWIDTH    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic [AWIDTH-1:0] i_addr,
    output logic [DWIDTH-1:0] o_data
);

    if (INIT_FILE != "") begin : g_no_file
        $error("rom_tremolo: only the built-in table is available");
    end

    always_ff @(posedge clk_i) begin
        o_data <= DWIDTH'({i_addr, {DWIDTH{1'b0}}} >> AWIDTH);
    end

endmodule

// File: rtl/lfo_rate_control.sv
// lfo_rate_control: time-multiplexed multi-channel LFO rate generator (table lookup, glide, NCO carry pulses).
module lfo_rate_control
    import lfo_rate_pkg::*;
#(
    parameter int    CHANNELS        = 2,
    parameter int    ACC_W           = 24,
    parameter int    INC_W           = 17,
    parameter int    RATE_AW         = 8,
    parameter int    DIV_LOG2        = 0,
    parameter int    GLIDE_SHIFT     = 4,
    parameter string RATE_TABLE_FILE = ""
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic                        sample_tick_i,
    input  logic [CHANNELS*RATE_AW-1:0] rate_num_i,
    input  logic [CHANNELS-1:0]         phase_reset_i,
    output logic [CHANNELS-1:0]         incr_en_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    logic [ACC_W-1:0]    r_acc [MAX_CHANNELS];
    logic [INC_W-1:0]    r_inc [MAX_CHANNELS];
    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] r_en;
    logic                r_busy;
    logic                r_ovr;
    logic                w_gen_tick;
    logic [RATE_AW-1:0]  w_addr;
    logic [INC_W-1:0]    w_rom;
    logic [INC_W-1:0]    w_new_inc;
    logic [ACC_W-1:0]    w_sum;
    logic                w_carry;
    logic                w_preset;
    logic [CHANNELS-1:0] w_pulses;

    if (DIV_LOG2 == 0) begin : g_nodiv
        assign w_gen_tick = sample_tick_i;
    end else begin : g_div
        logic [DIV_LOG2-1:0] r_div;
        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) r_div <= '0;
            else if (sample_tick_i) r_div <= r_div + 1'b1;
        end
        assign w_gen_tick = sample_tick_i && (&r_div);
    end

    rom_tremolo #(
        .DWIDTH    (INC_W),
        .AWIDTH    (RATE_AW),
        .INIT_FILE (RATE_TABLE_FILE)
    ) u_rom (
        .clk_i  (clk_i),
        .i_addr (w_addr),
        .o_data (w_rom)
    );

    // The glided increment feeds the adder in the same UPDATE cycle.
    always_comb begin
        w_addr   = '0;
        w_preset = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_ch == CH_W'(k)) begin
                w_addr   = rate_num_i[k*RATE_AW +: RATE_AW];
                w_preset = phase_reset_i[k];
            end
        end
        w_new_inc = INC_W'(32'(r_inc[r_ch]) +
                    unsigned'(glide_step(signed'(32'(w_rom)), signed'(32'(r_inc[r_ch])), GLIDE_SHIFT)));
        {w_carry, w_sum} = {1'b0, r_acc[r_ch]} + (ACC_W+1)'(w_new_inc);
        for (int k = 0; k < CHANNELS; k++) begin
            w_pulses[k] = (r_ch == CH_W'(k)) ? (w_carry && !w_preset) : r_pulse[k];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_pulse <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            for (int k = 0; k < MAX_CHANNELS; k++) begin
                r_acc[k] <= '0;
                r_inc[k] <= '0;
            end
        end else begin
            if (w_gen_tick && r_state != S_IDLE) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_gen_tick) begin
                        r_state <= S_FETCH;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_UPDATE;
                S_UPDATE: begin
                    r_inc[r_ch] <= w_new_inc;
                    r_acc[r_ch] <= w_preset ? '0 : w_sum;
                    r_pulse     <= w_pulses;
                    if (r_ch == CH_W'(CHANNELS-1)) begin
                        r_state <= S_EMIT;
                        r_en    <= w_pulses;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    r_en    <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign incr_en_o = r_en;
    assign busy_o    = r_busy;
    assign overrun_o = r_ovr;

endmodule

// File: tb/tb_lfo_rate_control.sv
// tb_lfo_rate_control: randomized ticks/rates/phase resets against an arithmetic per-channel NCO model,
// with expected pulse vectors queued at tick time and popped by an independent monitor.
module tb_lfo_rate_control;

    localparam int C        = 2;
    localparam int ACC_W    = 12;
    localparam int INC_W    = 12;
    localparam int RATE_AW  = 8;
    localparam int DIV_LOG2 = 1;
    localparam int GLIDE    = 2;
    localparam int SWEEP    = 2*C + 1;

    typedef struct {
        logic [C-1:0] en;
        int           cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 arst_i = 1'b1;
    logic                 sample_tick_i = 1'b0;
    logic [C*RATE_AW-1:0] rate_num_i = '0;
    logic [C-1:0]         phase_reset_i = '0;
    logic [C-1:0]         incr_en_o;
    logic                 busy_o;
    logic                 overrun_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    int   m_inc[C];
    int   m_acc[C];
    int   div_cnt = 0;
    int   busy_until = -1;
    bit   m_ovr = 1'b0;

    lfo_rate_control #(
        .CHANNELS    (C),
        .ACC_W       (ACC_W),
        .INC_W       (INC_W),
        .RATE_AW     (RATE_AW),
        .DIV_LOG2    (DIV_LOG2),
        .GLIDE_SHIFT (GLIDE)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst_i),
        .sample_tick_i (sample_tick_i),
        .rate_num_i    (rate_num_i),
        .phase_reset_i (phase_reset_i),
        .incr_en_o     (incr_en_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One generation tick of the reference: glide each channel's increment, then advance its phase.
    task automatic model_sweep(output logic [C-1:0] en);
        int rate, tgt, diff, step, s;
        for (int k = 0; k < C; k++) begin
            rate = int'(rate_num_i[k*RATE_AW +: RATE_AW]);
            tgt  = rate * (2**INC_W) / (2**RATE_AW);
            diff = tgt - m_inc[k];
            step = diff >>> GLIDE;
            if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
            m_inc[k] += step;
            if (phase_reset_i[k]) begin
                m_acc[k] = 0;
                en[k] = 1'b0;
            end else begin
                s = m_acc[k] + m_inc[k];
                en[k] = (s >= 2**ACC_W);
                m_acc[k] = s % (2**ACC_W);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < C; k++) begin
            m_inc[k] = 0;
            m_acc[k] = 0;
        end
        div_cnt = 0;
        busy_until = -1;
        m_ovr = 1'b0;
        q.delete();
    endtask

    task automatic tick();
        logic [C-1:0] en;
        sample_tick_i = 1'b1;
        if (div_cnt == 2**DIV_LOG2 - 1) begin
            if (cyc <= busy_until) m_ovr = 1'b1;
            else begin
                model_sweep(en);
                q.push_back('{en, cyc + SWEEP});
                busy_until = cyc + SWEEP;
            end
        end
        div_cnt = (div_cnt + 1) % (2**DIV_LOG2);
        @(posedge clk); #1;
        sample_tick_i = 1'b0;
        check("overrun", int'(overrun_o), int'(m_ovr));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Start an accepted sweep, then hit reset while channel 1 is in UPDATE.
    task automatic mid_reset();
        while (cyc <= busy_until) idle(1);
        while (div_cnt != 2**DIV_LOG2 - 1) tick();
        tick();
        idle(3);
        arst_i = 1'b1;
        #1;
        check("rst_incr_en", int'(incr_en_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_overrun", int'(overrun_o), 0);
        model_reset();
        @(posedge clk); #1;
        arst_i = 1'b0;
    endtask

    bit             prev_busy = 1'b0;
    bit             stray = 1'b0;
    int             run = 0;
    logic [C-1:0]   last_en;
    int             last_cyc;

    always @(negedge clk) begin
        if (arst_i) begin
            prev_busy = 1'b0;
            run = 0;
            stray = 1'b0;
        end else begin
            if (busy_o) begin
                if (run > 0 && last_en != '0) stray = 1'b1;
                run++;
                last_en = incr_en_o;
                last_cyc = cyc;
            end else if (prev_busy) begin
                checks++;
                if (run != SWEEP || stray) begin
                    errors++;
                    $display("FAIL busy_window: run=%0d stray=%0d expected run=%0d stray=0", run, stray, SWEEP);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_emit: got en=%b at cycle %0d, expected no sweep", last_en, last_cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (last_en !== mon_e.en || last_cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL pulse: got en=%b at cycle %0d expected en=%b at cycle %0d",
                                 last_en, last_cyc, mon_e.en, mon_e.cyc);
                    end
                end
                run = 0;
                stray = 1'b0;
            end
            prev_busy = busy_o;
        end
    end

    initial begin
        model_reset();
        idle(3);
        check("reset_incr_en", int'(incr_en_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_overrun", int'(overrun_o), 0);
        arst_i = 1'b0;
        idle(2);
        for (int i = 0; i < 400; i++) begin
            if (cyc > busy_until) begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int k = 0; k < C; k++) begin
                        case ($urandom_range(0, 3))
                            0:       rate_num_i[k*RATE_AW +: RATE_AW] = '0;
                            1:       rate_num_i[k*RATE_AW +: RATE_AW] = '1;
                            default: rate_num_i[k*RATE_AW +: RATE_AW] = RATE_AW'($urandom_range(0, 255));
                        endcase
                    end
                end
                phase_reset_i = ($urandom_range(0, 4) == 0) ? C'($urandom) : '0;
            end
            if (i == 200) mid_reset();
            tick();
            idle((i < 200) ? $urandom_range(2, 10) : $urandom_range(0, 7));
        end
        idle(20);
        check("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
